// File: rtl/plic_pkg.sv
// Shared PLIC definitions: target FSM encoding, ID width helper
// and the reserved "no interrupt" ID.
package plic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP    = 2'd1,
        SETTLE1 = 2'd2,
        SETTLE2 = 2'd3
    } state_t;

    localparam int ID_NONE = 0;

    function automatic int id_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/plic_max_sel.sv
// Combinational winner select: highest priority among qualifying
// sources, ties resolved toward the lowest source ID.
module plic_max_sel
    import plic_pkg::*;
#(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 3,
    parameter int ID_W   = id_width(NSRC)
) (
    input  logic [NSRC-1:0]        ip,
    input  logic [NSRC-1:0]        en,
    input  logic [NSRC*PRIO_W-1:0] prio,
    input  logic [PRIO_W-1:0]      threshold,
    output logic [ID_W-1:0]        win_id,
    output logic [PRIO_W-1:0]      win_prio
);

    logic [PRIO_W-1:0] p;

    // Scan upward; strict compare keeps the lower ID on a tie
    always_comb begin
        win_id   = ID_W'(ID_NONE);
        win_prio = '0;
        p        = '0;
        for (int i = 0; i < NSRC; i++) begin
            p = prio[i*PRIO_W +: PRIO_W];
            if (ip[i] && en[i] && (p > threshold) && (p > win_prio)) begin
                win_id   = ID_W'(i + 1);
                win_prio = p;
            end
        end
    end

endmodule

// File: rtl/plic_target.sv
// Per-hart PLIC target: arbitration, eip generation and the
// claim/complete handshake toward the gateways.
module plic_target
    import plic_pkg::*;
#(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 3,
    parameter int ID_W   = id_width(NSRC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NSRC-1:0]        src_ip,
    input  logic [NSRC*PRIO_W-1:0] src_prio,
    input  logic [NSRC-1:0]        src_en,
    input  logic [PRIO_W-1:0]      threshold,
    input  logic                   claim_req,
    output logic                   claim_ack,
    output logic [ID_W-1:0]        claim_id,
    input  logic                   complete_req,
    input  logic [ID_W-1:0]        complete_id,
    output logic [NSRC-1:0]        gw_claim,
    output logic [NSRC-1:0]        gw_complete,
    output logic                   eip
);

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   sel_id;
    logic [ID_W-1:0]   best_id;
    logic [ID_W-1:0]   claim_q;
    logic [PRIO_W-1:0] sel_prio;
    logic [PRIO_W-1:0] best_prio;
    logic [NSRC-1:0]   active;
    logic [NSRC-1:0]   claim_hot;
    logic [NSRC-1:0]   cmp_hot;
    logic [NSRC-1:0]   set_mask;
    logic [NSRC-1:0]   clr_mask;
    logic [NSRC-1:0]   gw_complete_q;
    logic              eip_q;

    plic_max_sel #(
        .NSRC   (NSRC),
        .PRIO_W (PRIO_W),
        .ID_W   (ID_W)
    ) u_sel (
        .ip        (src_ip),
        .en        (src_en),
        .prio      (src_prio),
        .threshold (threshold),
        .win_id    (sel_id),
        .win_prio  (sel_prio)
    );

    // Register the arbitration winner every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_id   <= ID_W'(ID_NONE);
            best_prio <= '0;
        end else begin
            best_id   <= sel_id;
            best_prio <= sel_prio;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: one response cycle, then two settle cycles
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (claim_req) state_next = RESP;
            RESP:    state_next = SETTLE1;
            SETTLE1: state_next = SETTLE2;
            SETTLE2: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the winner when a claim read is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            claim_q <= ID_W'(ID_NONE);
        end else if (state == IDLE && claim_req) begin
            claim_q <= best_id;
        end
    end

    // One-hot decode of the claimed and the completed IDs
    always_comb begin
        claim_hot = '0;
        cmp_hot   = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (claim_q == ID_W'(i + 1)) claim_hot[i] = 1'b1;
            if (complete_id == ID_W'(i + 1)) cmp_hot[i] = 1'b1;
        end
    end

    // Claim sets win over a complete hitting the same bit
    always_comb begin
        set_mask = (state == RESP) ? claim_hot : '0;
        clr_mask = complete_req ? (cmp_hot & active & ~set_mask) : '0;
    end

    // Active mask and registered complete pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active        <= '0;
            gw_complete_q <= '0;
        end else begin
            active        <= (active & ~clr_mask) | set_mask;
            gw_complete_q <= clr_mask;
        end
    end

    // eip held low while a claim is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eip_q <= 1'b0;
        end else begin
            eip_q <= (best_id != ID_W'(ID_NONE)) &&
                     (best_prio != '0) &&
                     (state_next == IDLE);
        end
    end

    assign claim_ack   = (state == RESP);
    assign claim_id    = claim_ack ? claim_q : ID_W'(ID_NONE);
    assign gw_claim    = set_mask;
    assign gw_complete = gw_complete_q;
    assign eip         = eip_q;

endmodule

// File: tb/tb_plic_target.sv
// Self-checking bench for plic_target: vector table plus
// hand-written claim/complete/reset sequences.
module tb_plic_target;

    logic        clk;
    logic        rst_n;
    logic [7:0]  src_ip;
    logic [23:0] src_prio;
    logic [7:0]  src_en;
    logic [2:0]  threshold;
    logic        claim_req;
    logic        claim_ack;
    logic [3:0]  claim_id;
    logic        complete_req;
    logic [3:0]  complete_id;
    logic [7:0]  gw_claim;
    logic [7:0]  gw_complete;
    logic        eip;

    int total = 0;
    int bad   = 0;

    logic [3:0] q[$];
    logic [3:0] mon_exp;

    typedef struct {
        logic [7:0]  ip;
        logic [7:0]  en;
        logic [23:0] prio;
        logic [2:0]  thr;
        logic [3:0]  id;
    } vec_t;

    vec_t vt[10];

    plic_target #(
        .NSRC   (8),
        .PRIO_W (3),
        .ID_W   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_ip       (src_ip),
        .src_prio     (src_prio),
        .src_en       (src_en),
        .threshold    (threshold),
        .claim_req    (claim_req),
        .claim_ack    (claim_ack),
        .claim_id     (claim_id),
        .complete_req (complete_req),
        .complete_id  (complete_id),
        .gw_claim     (gw_claim),
        .gw_complete  (gw_complete),
        .eip          (eip)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [23:0] pr(input int s, input int p);
        logic [23:0] v;
        v = '0;
        v[(s-1)*3 +: 3] = 3'(p);
        return v;
    endfunction

    function automatic logic [7:0] oh(input logic [3:0] id);
        logic [7:0] one;
        one = 8'd1;
        if (id == 4'd0) return 8'h00;
        return one << (id - 4'd1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: each acknowledge consumes the oldest expected ID
    always @(negedge clk) begin
        if (rst_n && claim_ack) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", {28'd0, claim_id}, 32'hffff_ffff);
            end else begin
                mon_exp = q.pop_front();
                chk("claim_id", {28'd0, claim_id}, {28'd0, mon_exp});
                chk("gw_claim", {24'd0, gw_claim}, {24'd0, oh(mon_exp)});
            end
        end
    end

    task automatic wait_ack(output int lat);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (claim_ack) begin
                lat = k;
                break;
            end
        end
        chk("ack_latency", lat, 1);
        if (lat == 0 && q.size() > 0) void'(q.pop_front());
    endtask

    task automatic do_claim(input logic [3:0] id, input bit hold);
        int lat;
        q.push_back(id);
        claim_req = 1'b1;
        wait_ack(lat);
        chk("ack_eip", {31'd0, eip}, 0);
        if (!hold) claim_req = 1'b0;
        if (id != 4'd0) src_ip[id - 4'd1] = 1'b0;
        @(negedge clk);
        chk("s1_noack", {31'd0, claim_ack}, 0);
        @(negedge clk);
        chk("s2_noack", {31'd0, claim_ack}, 0);
        @(negedge clk);
        if (hold) begin
            claim_req = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk("hold_noack", {31'd0, claim_ack}, 0);
            end
        end
    endtask

    task automatic do_complete(input logic [3:0] id, input logic [7:0] exp);
        complete_req = 1'b1;
        complete_id  = id;
        @(negedge clk);
        complete_req = 1'b0;
        complete_id  = 4'd0;
        chk($sformatf("cmp_pulse_%0d", id), {24'd0, gw_complete}, {24'd0, exp});
        @(negedge clk);
        chk("cmp_clear", {24'd0, gw_complete}, 0);
    endtask

    initial begin
        int lat;
        rst_n        = 1'b0;
        src_ip       = '0;
        src_prio     = '0;
        src_en       = '0;
        threshold    = '0;
        claim_req    = 1'b0;
        complete_req = 1'b0;
        complete_id  = '0;

        vt[0] = '{8'h04, 8'hff, pr(3, 5), 3'd2, 4'd3};
        vt[1] = '{8'h09, 8'hff, pr(1, 3) | pr(4, 0), 3'd3, 4'd0};
        vt[2] = '{8'h32, 8'hff, pr(2, 4) | pr(5, 7) | pr(6, 4), 3'd0, 4'd5};
        vt[3] = '{8'h22, 8'hff, pr(2, 4) | pr(5, 7) | pr(6, 4), 3'd0, 4'd2};
        vt[4] = '{8'h32, 8'hef, pr(2, 4) | pr(5, 7) | pr(6, 4), 3'd0, 4'd2};
        vt[5] = '{8'h80, 8'hff, pr(8, 7), 3'd6, 4'd8};
        vt[6] = '{8'h80, 8'hff, pr(8, 7), 3'd7, 4'd0};
        vt[7] = '{8'hff, 8'hff, 24'o11111111, 3'd0, 4'd1};
        vt[8] = '{8'h81, 8'hff, pr(1, 2) | pr(8, 3), 3'd0, 4'd8};
        vt[9] = '{8'h04, 8'hfb, pr(3, 5), 3'd0, 4'd0};

        repeat (2) @(negedge clk);
        chk("rst_eip", {31'd0, eip}, 0);
        chk("rst_ack", {31'd0, claim_ack}, 0);
        chk("rst_id", {28'd0, claim_id}, 0);
        chk("rst_gwc", {24'd0, gw_claim}, 0);
        chk("rst_gwd", {24'd0, gw_complete}, 0);
        rst_n = 1'b1;

        src_en    = 8'hff;
        src_prio  = pr(3, 5);
        threshold = 3'd2;
        src_ip    = 8'h04;
        @(negedge clk);
        chk("eip_lat1", {31'd0, eip}, 0);
        @(negedge clk);
        chk("eip_lat2", {31'd0, eip}, 1);
        do_claim(4'd3, 1'b0);
        do_complete(4'd3, 8'h04);

        do_complete(4'd3, 8'h00);
        do_complete(4'd9, 8'h00);
        do_complete(4'd0, 8'h00);

        for (int i = 0; i < 10; i++) begin
            src_ip    = vt[i].ip;
            src_en    = vt[i].en;
            src_prio  = vt[i].prio;
            threshold = vt[i].thr;
            repeat (2) @(negedge clk);
            chk($sformatf("vec%0d_eip", i), {31'd0, eip},
                {31'd0, (vt[i].id != 4'd0)});
            do_claim(vt[i].id, 1'b0);
            if (vt[i].id != 4'd0) do_complete(vt[i].id, oh(vt[i].id));
        end

        src_en    = 8'hff;
        threshold = 3'd0;
        src_prio  = pr(2, 4) | pr(5, 7) | pr(6, 4);
        src_ip    = 8'h32;
        repeat (2) @(negedge clk);
        chk("arb_eip0", {31'd0, eip}, 1);
        do_claim(4'd5, 1'b0);
        chk("arb_eip1", {31'd0, eip}, 1);
        do_claim(4'd2, 1'b0);
        chk("arb_eip2", {31'd0, eip}, 1);
        do_claim(4'd6, 1'b0);
        chk("arb_eip3", {31'd0, eip}, 0);
        do_complete(4'd5, 8'h10);
        do_complete(4'd2, 8'h02);
        do_complete(4'd6, 8'h20);

        src_prio  = pr(3, 5);
        threshold = 3'd2;
        src_ip    = 8'h04;
        repeat (2) @(negedge clk);
        do_claim(4'd3, 1'b1);
        do_complete(4'd3, 8'h04);

        src_prio = pr(2, 4);
        src_ip   = 8'h02;
        repeat (2) @(negedge clk);
        q.push_back(4'd2);
        claim_req = 1'b1;
        wait_ack(lat);
        complete_req = 1'b1;
        complete_id  = 4'd2;
        claim_req    = 1'b0;
        src_ip       = 8'h00;
        @(negedge clk);
        complete_req = 1'b0;
        complete_id  = 4'd0;
        chk("simul_nocmp", {24'd0, gw_complete}, 0);
        repeat (2) @(negedge clk);
        do_complete(4'd2, 8'h02);

        src_prio = pr(2, 4) | pr(3, 5);
        src_ip   = 8'h02;
        repeat (2) @(negedge clk);
        do_claim(4'd2, 1'b0);
        src_ip = 8'h04;
        repeat (2) @(negedge clk);
        q.push_back(4'd3);
        claim_req = 1'b1;
        wait_ack(lat);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_ack", {31'd0, claim_ack}, 0);
        chk("mrst_id", {28'd0, claim_id}, 0);
        chk("mrst_gwc", {24'd0, gw_claim}, 0);
        chk("mrst_gwd", {24'd0, gw_complete}, 0);
        chk("mrst_eip", {31'd0, eip}, 0);
        claim_req = 1'b0;
        src_ip    = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        do_complete(4'd2, 8'h00);
        do_complete(4'd3, 8'h00);
        src_ip = 8'h04;
        repeat (2) @(negedge clk);
        chk("post_rst_eip", {31'd0, eip}, 1);
        do_claim(4'd3, 1'b0);
        do_complete(4'd3, 8'h04);

        chk("sb_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/plic_target.md
# plic_target

Per-hart PLIC target controller. Collects `ip` lines from the per-source gateways, selects the highest-priority enabled pending source above the hart threshold, and drives the external interrupt line `eip`. Runs the claim/complete handshake between the hart-side register interface and the gateways, returning each gateway's one-cycle `claim` and `complete` pulses. One instance per hart context, between the gateway array and the PLIC register decoder.

## Interface
- `NSRC`, 8: number of sources. IDs run 1..NSRC; ID 0 means "none".
- `PRIO_W`, 3: priority width. Priority 0 means never interrupt.
- `ID_W`, $clog2(NSRC+1): width of the ID fields.

Ports:
- `clk` in 1: clock. Single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `src_ip` in NSRC: gateway `ip` lines; bit i is source i+1.
- `src_prio` in NSRC*PRIO_W: per-source priority; slice i is source i+1.
- `src_en` in NSRC: per-hart enable bits.
- `threshold` in PRIO_W: hart priority threshold.
- `claim_req` in 1: claim read request; held high until `claim_ack`.
- `claim_ack` out 1: one-cycle acknowledge; `claim_id` is valid in this cycle.
- `claim_id` out ID_W: claimed ID, or 0 when nothing qualifies.
- `complete_req` in 1: one-cycle complete-write strobe.
- `complete_id` in ID_W: ID being completed.
- `gw_claim` out NSRC: one-hot one-cycle claim pulse to the gateways.
- `gw_complete` out NSRC: one-hot one-cycle complete pulse to the gateways.
- `eip` out 1: external interrupt to the hart.

## Operation
- **Qualify.** Source i qualifies when `src_ip[i] & src_en[i] & (prio_i > threshold)` holds. The comparison is unsigned, so priority 0 never qualifies.
- **Select.** The winner has the highest priority among qualifying sources; ties go to the lowest ID. It is registered each cycle as `best_id` and `best_prio`, with `best_id`=0 when none qualify.
- **`eip`.** Registered `eip` = (`best_id` != 0) & (state == IDLE).
- **Active mask.** `active[NSRC]` is set on claim and cleared on complete.
- **FSM.** States: IDLE, RESP, SETTLE1, SETTLE2.
  - IDLE: if `claim_req` is high, latch `best_id` into `claim_id` and go to RESP.
  - RESP, one cycle:
    - Drive `claim_ack`=1.
    - If `claim_id` != 0, drive `gw_claim[claim_id-1]`=1 and set `active[claim_id-1]`.
    - Go to SETTLE1.
  - SETTLE1 -> SETTLE2 -> IDLE unconditionally. This gives the gateway one cycle to drop `ip` and `best_*` one cycle to re-evaluate.
  - `claim_req` is ignored outside IDLE.
- **Requester rule.** The requester deasserts `claim_req` in the cycle after `claim_ack`.
- **Complete.**
  - Accepted in any FSM state.
  - If `complete_id` is in 1..NSRC and `active[complete_id-1]`=1, then one cycle later drive `gw_complete[complete_id-1]`=1 and clear the active bit.
  - Otherwise the write is dropped silently: ID 0, ID > NSRC, or a source that is not active.
- **Simultaneous set and clear.** If a claim-set and a complete-clear hit the same active bit on the same edge, the set wins and the complete is dropped.
- **Config changes.** Changes to priority, enable or threshold affect `best_*` after one cycle. They never retract an issued `claim_ack`.
- **Reset mid-operation.** Reset returns to IDLE and clears `active`. All outputs go to 0 with no pulse issued.

## Timing
- Reset values: `eip`=0, `claim_ack`=0, `claim_id`=0, `gw_claim`=0, `gw_complete`=0; state IDLE; `best_id`=0; `active`=0.
- Latency from `src_ip` rising to `eip` is 2 cycles: `best_*` register, then `eip` register.
- Claim: `claim_req` sampled high in IDLE at edge N. At edge N+1, RESP begins: `claim_ack`, `claim_id` and `gw_claim` are all asserted for exactly one cycle, in the same cycle.
- `eip` is low from the cycle after the IDLE exit through SETTLE2. It is re-evaluated in the first IDLE cycle.
- Minimum spacing between claim acknowledges is 4 cycles.
- Complete: strobe at edge N gives a `gw_complete` pulse at N+1, exactly one cycle wide.

## Structure
- Shared package `plic_pkg` holds:
  - the state encoding (IDLE=2'd0, RESP=2'd1, SETTLE1=2'd2, SETTLE2=2'd3);
  - the ID-width function;
  - the ID 0 = none constant.
  The register decoder and the gateways also import this package.
- One sub-module, `plic_max_sel`: combinational winner select over NSRC sources (priority compare, lowest-ID tie-break). Its outputs feed the `best_*` registers in `plic_target`.

## Test plan
- **Single source.** Source 3 at priority 5, enabled, threshold 2; raise `src_ip[2]`. Expect `eip`=1 two cycles later. Then claim: expect `claim_id`=3, `gw_claim`=8'b0000_0100 for one cycle, and `eip`=0.
- **Arbitration.** Sources 2 and 6 both at priority 4, source 5 at priority 7, all pending. Three claims with gateways modelled return IDs 5, 2, 6 in that order.
- **Threshold and priority 0.** Source 1 at priority 3 with threshold 3, and source 4 at priority 0, both pending: `eip` stays 0 and a claim returns `claim_id`=0 with `gw_claim`=0.
- **Complete filtering.**
  - Complete ID 3 while not active: `gw_complete`=0.
  - Complete ID 9 with NSRC=8: ignored.
  - Claim 3, then complete 3: `gw_complete[2]` pulses one cycle later.
- **Simultaneous events.** Complete source 2 in the same cycle as the RESP claim of source 2: `active[1]` stays 1 and no `gw_complete` pulse. Also check that `claim_req` held during SETTLE produces no second ack.
- **Reset.** Assert `rst_n`=0 during RESP: all outputs 0 immediately, and after release the state is IDLE with `active`=0.
